// File: rtl/uart_prog_loader_pkg.sv
// Shared types and constants for the UART program loader.
package uart_prog_loader_pkg;

   typedef enum logic [1:0] {
      R_IDLE,
      R_START,
      R_DATA,
      R_STOP
   } rx_state_t;

   typedef enum logic [2:0] {
      L_TGT,
      L_CNTL,
      L_CNTH,
      L_DATA,
      L_DONE
   } ld_state_t;

   localparam logic TGT_IMEM    = 1'b0;
   localparam logic TGT_DMEM    = 1'b1;
   localparam int   ADR_TGT_BIT = 14;

endpackage

// File: rtl/uart_prog_loader_rx_byte.sv
// 8N1 byte receiver: 2-flop synchronizer, mid-bit sampling, registered outputs.
module uart_rx_byte
   import uart_prog_loader_pkg::*;
#(
   parameter int BIT_CYC = 78
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx_i,
   output logic       byte_vld_o,
   output logic [7:0] byte_o,
   output logic       frame_err_o
);

   localparam int            CW   = $clog2(BIT_CYC);
   localparam logic [CW-1:0] FULL = CW'(BIT_CYC - 1);
   localparam logic [CW-1:0] HALF = CW'(BIT_CYC / 2 - 1);

   logic [1:0]    sync_q, sync_d;
   logic          prev_q, prev_d;
   rx_state_t     state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    sh_q, sh_d;
   logic          vld_q, vld_d;
   logic          err_q, err_d;
   logic          rx_s;

   assign rx_s        = sync_q[1];
   assign byte_vld_o  = vld_q;
   assign byte_o      = sh_q;
   assign frame_err_o = err_q;

   // Receiver FSM: start-edge detect, half-bit start check, 8 data bits, stop check.
   always_comb begin
      sync_d  = {sync_q[0], rx_i};
      prev_d  = rx_s;
      state_d = state_q;
      cnt_d   = cnt_q + 1'b1;
      bit_d   = bit_q;
      sh_d    = sh_q;
      vld_d   = 1'b0;
      err_d   = 1'b0;
      case (state_q)
         R_IDLE: begin
            cnt_d = '0;
            if (prev_q && !rx_s) state_d = R_START;
         end
         R_START: begin
            if (cnt_q == HALF) begin
               cnt_d   = '0;
               bit_d   = '0;
               // Line back high at mid-start means the edge was a glitch.
               state_d = rx_s ? R_IDLE : R_DATA;
            end
         end
         R_DATA: begin
            if (cnt_q == FULL) begin
               cnt_d = '0;
               sh_d  = {rx_s, sh_q[7:1]};
               bit_d = bit_q + 1'b1;
               if (bit_q == 3'd7) state_d = R_STOP;
            end
         end
         R_STOP: begin
            if (cnt_q == FULL) begin
               cnt_d   = '0;
               state_d = R_IDLE;
               if (rx_s) vld_d = 1'b1;
               else      err_d = 1'b1;
            end
         end
         default: state_d = R_IDLE;
      endcase
   end

   // Receiver state registers; the synchronizer resets to the idle (high) level.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q  <= 2'b11;
         prev_q  <= 1'b1;
         state_q <= R_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         sh_q    <= '0;
         vld_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         prev_q  <= prev_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         sh_q    <= sh_d;
         vld_q   <= vld_d;
         err_q   <= err_d;
      end
   end

endmodule

// File: rtl/uart_prog_loader.sv
// UART boot loader: parses TGT/CNT/data frames into 32-bit programming-port writes.
module uart_prog_loader
   import uart_prog_loader_pkg::*;
#(
   parameter int CLK_HZ       = 10_000_000,
   parameter int BAUD         = 128_000,
   parameter int TIMEOUT_BITS = 64
) (
   input  logic        upg_clk_i,
   input  logic        upg_rst_n_i,
   input  logic        upg_rx_i,
   output logic        upg_clk_o,
   output logic        upg_wen_o,
   output logic [14:0] upg_adr_o,
   output logic [31:0] upg_dat_o,
   output logic        upg_done_o,
   output logic        upg_err_o,
   output logic        upg_tx_o
);

   localparam int BIT_CYC = CLK_HZ / BAUD;
   localparam int TO_LIM  = TIMEOUT_BITS * BIT_CYC;
   localparam int TW      = $clog2(TO_LIM + 1);

   logic        byte_vld;
   logic [7:0]  rx_byte;
   logic        frame_err;

   ld_state_t   state_q, state_d;
   logic        tgt_q, tgt_d;
   logic [14:0] rem_q, rem_d;
   logic [13:0] widx_q, widx_d;
   logic [1:0]  bcnt_q, bcnt_d;
   logic [23:0] word_q, word_d;
   logic [14:0] adr_q, adr_d;
   logic [31:0] dat_q, dat_d;
   logic        wen_q, wen_d;
   logic        done_q, done_d;
   logic        to_err_q, to_err_d;
   logic [TW-1:0] to_q, to_d;
   logic        timed;
   logic [14:0] n_full;

   uart_rx_byte #(.BIT_CYC(BIT_CYC)) u_rx (
      .clk         (upg_clk_i),
      .rst_n       (upg_rst_n_i),
      .rx_i        (upg_rx_i),
      .byte_vld_o  (byte_vld),
      .byte_o      (rx_byte),
      .frame_err_o (frame_err)
   );

   assign upg_clk_o  = upg_clk_i;
   assign upg_tx_o   = 1'b1;
   assign upg_wen_o  = wen_q;
   assign upg_adr_o  = adr_q;
   assign upg_dat_o  = dat_q;
   assign upg_done_o = done_q;
   assign upg_err_o  = frame_err | to_err_q;

   assign timed  = (state_q == L_CNTL) || (state_q == L_CNTH) || (state_q == L_DATA);
   assign n_full = {rx_byte[6:0], rem_q[7:0]};

   // Loader FSM, inter-byte timeout and little-endian word assembly.
   always_comb begin
      state_d  = state_q;
      tgt_d    = tgt_q;
      rem_d    = rem_q;
      widx_d   = widx_q;
      bcnt_d   = bcnt_q;
      word_d   = word_q;
      adr_d    = adr_q;
      dat_d    = dat_q;
      wen_d    = 1'b0;
      // Done follows the cycle in which the FSM sits in L_DONE (i.e. after the last write).
      done_d   = done_q | (state_q == L_DONE);
      to_err_d = 1'b0;
      to_d     = (timed && !byte_vld) ? to_q + 1'b1 : '0;

      if (timed && !byte_vld && (to_q == TW'(TO_LIM - 1))) begin
         // Abandon the frame; writes already issued stay in memory.
         to_err_d = 1'b1;
         state_d  = L_TGT;
         widx_d   = '0;
         bcnt_d   = '0;
         word_d   = '0;
         to_d     = '0;
      end else if (byte_vld) begin
         case (state_q)
            L_TGT: begin
               tgt_d   = rx_byte[0];
               state_d = L_CNTL;
            end
            L_CNTL: begin
               rem_d   = {7'd0, rx_byte};
               state_d = L_CNTH;
            end
            L_CNTH: begin
               rem_d = n_full;
               if (n_full == 15'd0) begin
                  state_d = L_DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d = L_DATA;
               end
            end
            L_DATA: begin
               bcnt_d = bcnt_q + 1'b1;
               case (bcnt_q)
                  2'd0: word_d[7:0]   = rx_byte;
                  2'd1: word_d[15:8]  = rx_byte;
                  2'd2: word_d[23:16] = rx_byte;
                  default: begin
                     dat_d              = {rx_byte, word_q};
                     adr_d[ADR_TGT_BIT] = tgt_q;
                     adr_d[13:0]        = widx_q;
                     wen_d              = 1'b1;
                     widx_d             = widx_q + 1'b1;
                     rem_d              = rem_q - 15'd1;
                     word_d             = '0;
                     if (rem_q == 15'd1) state_d = L_DONE;
                  end
               endcase
            end
            default: ;
         endcase
      end
   end

   // Loader state registers.
   always_ff @(posedge upg_clk_i or negedge upg_rst_n_i) begin
      if (!upg_rst_n_i) begin
         state_q  <= L_TGT;
         tgt_q    <= TGT_IMEM;
         rem_q    <= '0;
         widx_q   <= '0;
         bcnt_q   <= '0;
         word_q   <= '0;
         adr_q    <= '0;
         dat_q    <= '0;
         wen_q    <= 1'b0;
         done_q   <= 1'b0;
         to_err_q <= 1'b0;
         to_q     <= '0;
      end else begin
         state_q  <= state_d;
         tgt_q    <= tgt_d;
         rem_q    <= rem_d;
         widx_q   <= widx_d;
         bcnt_q   <= bcnt_d;
         word_q   <= word_d;
         adr_q    <= adr_d;
         dat_q    <= dat_d;
         wen_q    <= wen_d;
         done_q   <= done_d;
         to_err_q <= to_err_d;
         to_q     <= to_d;
      end
   end

endmodule

// File: tb/tb_uart_prog_loader.sv
// Scoreboard bench for uart_prog_loader: directed frames, expected writes queued, monitor checks.
module tb_uart_prog_loader;

   localparam int BIT = 16;   // 10 MHz / 625 kbaud

   typedef struct {
      logic [14:0] adr;
      logic [31:0] dat;
      bit          last;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        rx = 1'b1;
   logic        clk_o, wen, done, err, tx;
   logic [14:0] adr;
   logic [31:0] dat;

   exp_t        exp_q[$];
   logic [7:0]  tx_q[$];
   int          checks = 0;
   int          errors = 0;
   int          wr_cnt = 0;
   int          err_cnt = 0;
   int          e0, w0;

   uart_prog_loader #(.CLK_HZ(10_000_000), .BAUD(625_000), .TIMEOUT_BITS(64)) dut (
      .upg_clk_i   (clk),
      .upg_rst_n_i (rst_n),
      .upg_rx_i    (rx),
      .upg_clk_o   (clk_o),
      .upg_wen_o   (wen),
      .upg_adr_o   (adr),
      .upg_dat_o   (dat),
      .upg_done_o  (done),
      .upg_err_o   (err),
      .upg_tx_o    (tx)
   );

   always #50 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input bit stop_ok);
      rx = 1'b0;
      repeat (BIT) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (BIT) @(negedge clk);
      end
      rx = stop_ok;
      repeat (BIT) @(negedge clk);
      if (!stop_ok) begin
         rx = 1'b1;
         repeat (2 * BIT) @(negedge clk);
      end
      rx = 1'b1;
   endtask

   task automatic send_q();
      while (tx_q.size() > 0) send_byte(tx_q.pop_front(), 1'b1);
      repeat (3 * BIT) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      repeat (5) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
   endtask

   task automatic expect_wr(input logic [14:0] a, input logic [31:0] d, input bit last);
      exp_t e;
      e.adr = a; e.dat = d; e.last = last;
      exp_q.push_back(e);
   endtask

   // Monitor: samples 1 time unit after each rising edge, pops on every write strobe.
   task automatic monitor();
      bit   chk_done = 1'b0;
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (chk_done) begin
            chk("done_after_last_wr", {31'd0, done}, 32'd1);
            chk_done = 1'b0;
         end
         if (err) err_cnt++;
         if (wen) begin
            wr_cnt++;
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_wr actual adr=%h dat=%h expected none", adr, dat);
            end else begin
               e = exp_q.pop_front();
               chk("wr_adr", {17'd0, adr}, {17'd0, e.adr});
               chk("wr_dat", dat, e.dat);
               if (!e.last) chk("done_low_mid_frame", {31'd0, done}, 32'd0);
               chk_done = e.last;
            end
         end
      end
   endtask

   task automatic chk_empty(input string name);
      chk(name, exp_q.size(), 32'd0);
      exp_q.delete();
   endtask

   initial begin
      fork
         monitor();
      join_none

      // Reset held, line toggling: everything at reset values.
      repeat (3) @(negedge clk);
      for (int i = 0; i < 40; i++) begin
         rx = ~rx;
         @(negedge clk);
      end
      rx = 1'b1;
      #1;
      chk("rst_wen", {31'd0, wen}, 32'd0);
      chk("rst_adr", {17'd0, adr}, 32'd0);
      chk("rst_dat", dat, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_err", {31'd0, err}, 32'd0);
      chk("rst_tx", {31'd0, tx}, 32'd1);
      rst_n = 1'b1;
      repeat (20 * BIT) @(negedge clk);
      chk("idle_no_wr", wr_cnt, 32'd0);
      chk("idle_no_err", err_cnt, 32'd0);

      // One word to instruction ROM.
      expect_wr(15'h0000, 32'h12345678, 1'b1);
      tx_q = '{8'h00, 8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
      send_q();
      chk_empty("t1_all_writes");
      chk("t1_done", {31'd0, done}, 32'd1);

      // Two words to data memory, then trailing bytes that must be ignored.
      do_reset();
      chk("t2_done_cleared", {31'd0, done}, 32'd0);
      expect_wr(15'h4000, 32'hDEADBEEF, 1'b0);
      expect_wr(15'h4001, 32'h01020304, 1'b1);
      tx_q = '{8'h01, 8'h02, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h04, 8'h03, 8'h02, 8'h01};
      send_q();
      chk_empty("t2_all_writes");
      w0 = wr_cnt;
      tx_q = '{8'h00, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
      send_q();
      chk("t2_ignored_after_done", wr_cnt - w0, 32'd0);
      chk("t2_done", {31'd0, done}, 32'd1);

      // Framing error on the 2nd data byte: that byte is dropped.
      do_reset();
      e0 = err_cnt;
      expect_wr(15'h0000, 32'h44332211, 1'b1);
      tx_q = '{8'h00, 8'h01, 8'h00, 8'h11};
      send_q();
      send_byte(8'h99, 1'b0);
      tx_q = '{8'h22, 8'h33, 8'h44};
      send_q();
      chk_empty("t3_all_writes");
      chk("t3_err_pulses", err_cnt - e0, 32'd1);

      // Timeout mid-word, then a fresh frame.
      do_reset();
      e0 = err_cnt;
      w0 = wr_cnt;
      tx_q = '{8'h00, 8'h02, 8'h00, 8'h11, 8'h22};
      send_q();
      repeat (80 * BIT) @(negedge clk);
      chk("t4_err_pulses", err_cnt - e0, 32'd1);
      chk("t4_no_wr", wr_cnt - w0, 32'd0);
      expect_wr(15'h0000, 32'hDDCCBBAA, 1'b1);
      tx_q = '{8'h00, 8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
      send_q();
      chk_empty("t4_all_writes");

      // Reset after 3 data bytes aborts without a write.
      do_reset();
      w0 = wr_cnt;
      tx_q = '{8'h00, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33};
      send_q();
      do_reset();
      chk("t5_no_wr", wr_cnt - w0, 32'd0);
      chk("t5_done_low", {31'd0, done}, 32'd0);
      expect_wr(15'h0000, 32'h12345678, 1'b1);
      tx_q = '{8'h00, 8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
      send_q();
      chk_empty("t5_all_writes");
      chk("t5_done", {31'd0, done}, 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
